// File: rtl/rr_channel_mux.sv
// rr_channel_mux: registered N:1 stream multiplexer with valid/ready handshake.
//
// Selects one of CHANNELS input streams (WIDTH bits each) and forwards it through a single
// output register stage. Two selection modes:
//   mode = 0 : addressed, channel `addr` is granted when it is in range and valid
//   mode = 1 : round-robin, first valid channel at or after the pointer (with wrap-around)
// Backpressure reaches only the granted producer; at most one in_ready bit is high.
//
// Optional feature: define RR_MUX_PARITY_EN to add out_parity (XOR of out_data), registered
// alongside out_data.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   mode       0 = addressed select, 1 = round-robin select
//   addr       channel address (mode = 0 only)
//   in_data    flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept strobe (combinational)
//   out_data   registered selected data
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_parity (RR_MUX_PARITY_EN only) XOR of out_data bits
//   out_ready  consumer accepts the word this cycle
module rr_channel_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          addr,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
`ifdef RR_MUX_PARITY_EN
    output logic                      out_parity,
`endif
    input  logic                      out_ready
);

    // Output register stage and round-robin pointer.
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef RR_MUX_PARITY_EN
    logic             out_parity_q, out_parity_d;
`endif

    // Arbitration signals.
    logic             rr_hi_found, rr_lo_found;
    logic [SEL_W-1:0] rr_hi_idx, rr_lo_idx;
    logic             addr_ok;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] ptr_nxt;
    logic             load;
    logic             xfer;

    // Round-robin search split in two: lowest valid channel at or above the pointer (hi), and
    // lowest valid channel overall (lo). If nothing is found above the pointer, the search has
    // wrapped, and the lowest overall is the first one below the pointer.
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_found = 1'b0;
        rr_lo_idx   = '0;
        // Descending scan so the last hit is the lowest index.
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_lo_found = 1'b1;
                rr_lo_idx   = SEL_W'(i);
                if (i >= int'(ptr_q)) begin
                    rr_hi_found = 1'b1;
                    rr_hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Addressed grant: compare against each real channel so an out-of-range address never hits.
    always_comb begin
        addr_ok = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if ((int'(addr) == i) && in_valid[i]) begin
                addr_ok = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode) begin
            gnt_valid = rr_lo_found;
            gnt_idx   = rr_hi_found ? rr_hi_idx : rr_lo_idx;
        end else begin
            gnt_valid = addr_ok;
            gnt_idx   = addr;
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = load && gnt_valid && !reset;

    // Data select and one-hot ready for the granted channel.
    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (int'(gnt_idx) == i) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    // Wrap against CHANNELS, which need not be a power of two.
    assign ptr_nxt = (int'(gnt_idx) == int'(CHANNELS) - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_PARITY_EN
        out_parity_d = out_parity_q;
`endif
        if (load) begin
            // Drain when nothing is granted; data/chan keep their last values.
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = gnt_data;
                out_chan_d = gnt_idx;
`ifdef RR_MUX_PARITY_EN
                out_parity_d = ^gnt_data;
`endif
                if (mode) begin
                    ptr_d = ptr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
`ifdef RR_MUX_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
`ifdef RR_MUX_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
`ifdef RR_MUX_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed testbench for rr_channel_mux: a 4-channel instance (a_*) and a 3-channel instance
// (b_*) sharing one clock. Inputs change 1 time unit after the rising edge; combinational
// in_ready is checked before the next edge and registered outputs 1 unit after it.
module tb_rr_channel_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance.
    logic        a_reset;
    logic        a_mode;
    logic [1:0]  a_addr;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_chan;
    logic        a_out_valid;
    logic        a_out_ready;
`ifdef RR_MUX_PARITY_EN
    logic        a_out_parity;
    logic        b_out_parity;
`endif

    // 3-channel instance.
    logic        b_reset;
    logic        b_mode;
    logic [1:0]  b_addr;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_chan;
    logic        b_out_valid;
    logic        b_out_ready;

    rr_channel_mux #(
        .WIDTH    (8),
        .CHANNELS (4),
        .SEL_W    (2)
    ) u_dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .mode       (a_mode),
        .addr       (a_addr),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .out_data   (a_out_data),
        .out_chan   (a_out_chan),
        .out_valid  (a_out_valid),
`ifdef RR_MUX_PARITY_EN
        .out_parity (a_out_parity),
`endif
        .out_ready  (a_out_ready)
    );

    rr_channel_mux #(
        .WIDTH    (8),
        .CHANNELS (3),
        .SEL_W    (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .mode       (b_mode),
        .addr       (b_addr),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out_data   (b_out_data),
        .out_chan   (b_out_chan),
        .out_valid  (b_out_valid),
`ifdef RR_MUX_PARITY_EN
        .out_parity (b_out_parity),
`endif
        .out_ready  (b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_out(input string tag, input logic v, input logic [7:0] d,
                               input logic [1:0] c);
        check({tag, ".valid"}, {31'd0, a_out_valid}, {31'd0, v});
        check({tag, ".data"},  {24'd0, a_out_data},  {24'd0, d});
        check({tag, ".chan"},  {30'd0, a_out_chan},  {30'd0, c});
    endtask

    task automatic check_b_out(input string tag, input logic v, input logic [7:0] d,
                               input logic [1:0] c);
        check({tag, ".valid"}, {31'd0, b_out_valid}, {31'd0, v});
        check({tag, ".data"},  {24'd0, b_out_data},  {24'd0, d});
        check({tag, ".chan"},  {30'd0, b_out_chan},  {30'd0, c});
    endtask

    initial begin
        // ---------------- reset, with a request pending ----------------
        a_reset = 1'b1; a_mode = 1'b0; a_addr = 2'd0;
        a_in_data = 32'h44_A5_22_11; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        b_reset = 1'b1; b_mode = 1'b1; b_addr = 2'd0;
        b_in_data = 24'h0C_0B_0A; b_in_valid = 3'b000; b_out_ready = 1'b1;
        #1;
        check("a_rst_in_ready", {28'd0, a_in_ready}, 32'd0);
        tick();
        tick();
        check("a_rst_in_ready2", {28'd0, a_in_ready}, 32'd0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        a_in_valid = 4'b0000;
        #1;
        check_a_out("a_rst", 1'b0, 8'h00, 2'd0);

        // ---------------- addressed: ch2 ----------------
        a_mode = 1'b0; a_addr = 2'd2; a_in_valid = 4'b0100;
        #1;
        check("a_addr2_in_ready", {28'd0, a_in_ready}, 32'b0100);
        tick();
        check_a_out("a_addr2", 1'b1, 8'hA5, 2'd2);

        // ---------------- addressed: ch1 not valid -> drain ----------------
        a_addr = 2'd1; a_in_valid = 4'b1101;
        #1;
        check("a_addr1_in_ready", {28'd0, a_in_ready}, 32'd0);
        tick();
        check_a_out("a_drain", 1'b0, 8'hA5, 2'd2);

        // ---------------- round-robin, all valid, pointer 0 ----------------
        a_mode = 1'b1; a_in_valid = 4'b1111; a_in_data = 32'h43_32_21_10;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] c;
            logic [7:0] d;
            c = 2'(k % 4);
            d = {2'd0, c, 2'd0, c} + 8'h10 - {6'd0, c} + {6'd0, c};
            d = (c == 2'd0) ? 8'h10 : (c == 2'd1) ? 8'h21 : (c == 2'd2) ? 8'h32 : 8'h43;
            #1;
            check($sformatf("a_rr%0d_in_ready", k), {28'd0, a_in_ready}, 32'd1 << c);
            tick();
            check_a_out($sformatf("a_rr%0d", k), 1'b1, d, c);
        end
        // pointer now 1

        // ---------------- stall after a word from ch1 ----------------
        tick();
        check_a_out("a_pre_stall", 1'b1, 8'h21, 2'd1);
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("a_stall%0d_in_ready", k), {28'd0, a_in_ready}, 32'd0);
            tick();
            check_a_out($sformatf("a_stall%0d", k), 1'b1, 8'h21, 2'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("a_release_in_ready", {28'd0, a_in_ready}, 32'b0100);
        tick();
        check_a_out("a_release", 1'b1, 8'h32, 2'd2);
        // pointer now 3

        // ---------------- pointer retained across a mode-0 transfer ----------------
        a_mode = 1'b0; a_addr = 2'd0;
        #1;
        check("a_m0_in_ready", {28'd0, a_in_ready}, 32'b0001);
        tick();
        check_a_out("a_m0", 1'b1, 8'h10, 2'd0);
        a_mode = 1'b1;
        #1;
        check("a_m1_ret_in_ready", {28'd0, a_in_ready}, 32'b1000);
        tick();
        check_a_out("a_m1_ret", 1'b1, 8'h43, 2'd3);
        // pointer now 0; one more transfer moves it to 1
        tick();
        check_a_out("a_pre_rst", 1'b1, 8'h10, 2'd0);

        // ---------------- reset during a stall ----------------
        a_out_ready = 1'b0;
        tick();
        check_a_out("a_stall_hold", 1'b1, 8'h10, 2'd0);
        a_reset = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("a_rst_mid_in_ready", {28'd0, a_in_ready}, 32'd0);
        tick();
        a_reset = 1'b0;
        check_a_out("a_rst_mid", 1'b0, 8'h00, 2'd0);
`ifdef RR_MUX_PARITY_EN
        check("a_rst_parity", {31'd0, a_out_parity}, 32'd0);
`endif
        // pointer back to 0: all valid grants ch0
        #1;
        check("a_ptr_rst_in_ready", {28'd0, a_in_ready}, 32'b0001);
        a_mode = 1'b0; a_addr = 2'd1; a_in_data = 32'h00_00_07_00;
        #1;
        check("a_par_in_ready", {28'd0, a_in_ready}, 32'b0010);
        tick();
        check_a_out("a_par", 1'b1, 8'h07, 2'd1);
`ifdef RR_MUX_PARITY_EN
        check("a_parity", {31'd0, a_out_parity}, 32'd1);
`endif

        // ---------------- 3-channel instance: non-power-of-two wrap ----------------
        b_mode = 1'b1; b_in_valid = 3'b001;
        #1;
        check("b_ch0_in_ready", {29'd0, b_in_ready}, 32'b001);
        tick();
        check_b_out("b_ch0", 1'b1, 8'h0A, 2'd0);
        // pointer now 1
        b_in_valid = 3'b101;
        #1;
        check("b_wrap2_in_ready", {29'd0, b_in_ready}, 32'b100);
        tick();
        check_b_out("b_wrap2", 1'b1, 8'h0C, 2'd2);
        #1;
        check("b_wrap0_in_ready", {29'd0, b_in_ready}, 32'b001);
        tick();
        check_b_out("b_wrap0", 1'b1, 8'h0A, 2'd0);
        // pointer now 1
        b_in_valid = 3'b111;
        #1;
        check("b_ptr1_in_ready", {29'd0, b_in_ready}, 32'b010);
        tick();
        check_b_out("b_ptr1", 1'b1, 8'h0B, 2'd1);
        // out-of-range address never grants
        b_mode = 1'b0; b_addr = 2'd3;
        #1;
        check("b_oor_in_ready", {29'd0, b_in_ready}, 32'd0);
        tick();
        check_b_out("b_oor", 1'b0, 8'h0B, 2'd1);
        #1;
        check("b_oor_in_ready2", {29'd0, b_in_ready}, 32'd0);
        tick();
        check("b_oor_valid2", {31'd0, b_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
